// File: rtl/mod3_frame_tx_pkg.sv
// Shared constants and FSM encoding for the mod-3 frame serializer.
package mod3_frame_tx_pkg;

    localparam int W_MIN   = 2;
    localparam int W_MAX   = 32;
    localparam int GAP_MIN = 0;
    localparam int GAP_MAX = 7;
    localparam int GAP_CW  = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        CATCH = 3'd2,
        GAPW  = 3'd3,
        HOLD  = 3'd4
    } state_e;

endpackage

// File: rtl/mod3_frame_tx_piso.sv
// Parallel-in serial-out shifter with a down-counting bit index.
module piso_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] din_i,
    output logic         msb_o,
    output logic         first_o,
    output logic         last_o
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_TOP = CW'(W-1);

    logic [W-1:0]  sr_q,  sr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = din_i;
            cnt_d = CNT_TOP;
        end else if (shift_i) begin
            sr_d = {sr_q[W-2:0], 1'b0};
            // Counter parks at zero after the last bit rather than wrapping.
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign msb_o   = sr_q[W-1];
    assign first_o = (cnt_q == CNT_TOP);
    assign last_o  = (cnt_q == '0);

endmodule

// File: rtl/mod3_frame_tx.sv
// Serializes buffered words to an external mod-3 counter and returns {word, verdict} records.
module mod3_frame_tx
    import mod3_frame_tx_pkg::*;
#(
    parameter int W   = 8,
    parameter int GAP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         start,
    output logic         stop,
    output logic         data,
    input  logic         result,
    output logic         out_valid,
    output logic [W-1:0] out_word,
    output logic         out_div3,
    input  logic         out_ready
);
    localparam int GAP_L = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(GAP_L);

    state_e              state_q, state_d;
    logic                en_q;
    logic                buf_full_q, buf_full_d;
    logic [W-1:0]        buf_q, buf_d;
    logic [W-1:0]        tag_q, tag_d;
    logic [GAP_CW-1:0]   gap_q, gap_d;
    logic                ov_q, ov_d;
    logic [W-1:0]        word_q, word_d;
    logic                div3_q, div3_d;
    logic                load, shift, decide;
    logic                sh_msb, sh_first, sh_last;

    piso_shifter #(.W(W)) u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .shift_i (shift),
        .din_i   (buf_q),
        .msb_o   (sh_msb),
        .first_o (sh_first),
        .last_o  (sh_last)
    );

    always_comb begin
        state_d    = state_q;
        buf_full_d = buf_full_q;
        buf_d      = buf_q;
        tag_d      = tag_q;
        gap_d      = gap_q;
        ov_d       = ov_q;
        word_d     = word_q;
        div3_d     = div3_q;
        load       = 1'b0;
        shift      = 1'b0;
        decide     = 1'b0;

        if (ov_q && out_ready) ov_d = 1'b0;
        if (in_valid && in_ready) begin
            buf_full_d = 1'b1;
            buf_d      = in_data;
        end

        case (state_q)
            IDLE:  decide = 1'b1;
            SHIFT: begin
                shift = 1'b1;
                if (sh_last) state_d = CATCH;
            end
            CATCH: begin
                ov_d   = 1'b1;
                word_d = tag_q;
                div3_d = result;
                if (GAP > 0) begin
                    state_d = GAPW;
                    gap_d   = GAP_LAST;
                end else begin
                    decide = 1'b1;
                end
            end
            GAPW: begin
                if (gap_q == '0) decide = 1'b1;
                else             gap_d  = gap_q - 1'b1;
            end
            HOLD:    decide = 1'b1;
            default: state_d = IDLE;
        endcase

        // A frame may only start once the record slot is free next cycle, so the
        // next CATCH can never overwrite an untaken record.
        if (decide) begin
            if (buf_full_q && !ov_d) begin
                load       = 1'b1;
                tag_d      = buf_q;
                buf_full_d = 1'b0;
                state_d    = SHIFT;
            end else if (ov_d) begin
                state_d = HOLD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            tag_q      <= '0;
            gap_q      <= '0;
            ov_q       <= 1'b0;
            word_q     <= '0;
            div3_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= 1'b1;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            tag_q      <= tag_d;
            gap_q      <= gap_d;
            ov_q       <= ov_d;
            word_q     <= word_d;
            div3_q     <= div3_d;
        end
    end

    assign in_ready  = en_q & ~buf_full_q;
    assign start     = (state_q == SHIFT) & sh_first;
    assign stop      = (state_q == SHIFT) & sh_last;
    assign data      = (state_q == SHIFT) & sh_msb;
    assign out_valid = ov_q;
    assign out_word  = word_q;
    assign out_div3  = div3_q;

endmodule

// File: tb/tb_mod3_frame_tx.sv
// Bench for mod3_frame_tx: a W=8/GAP=1 instance and a W=2/GAP=0 instance, each
// driven against a behavioural mod-3 counter.
module tb_mod3_frame_tx;

    typedef struct {
        logic [31:0] word;
        logic        div3;
    } rec_t;

    typedef struct {
        logic [7:0] word;
        logic       exp_div3;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A: W=8, GAP=1 ----------------
    logic       a_in_valid, a_in_ready, a_start, a_stop, a_data, a_result;
    logic       a_out_valid, a_out_div3, a_out_ready;
    logic [7:0] a_in_data, a_out_word;

    mod3_frame_tx #(.W(8), .GAP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .start(a_start), .stop(a_stop), .data(a_data),
        .result(a_result), .out_valid(a_out_valid), .out_word(a_out_word),
        .out_div3(a_out_div3), .out_ready(a_out_ready)
    );

    // ---------------- DUT B: W=2, GAP=0 ----------------
    logic       b_in_valid, b_in_ready, b_start, b_stop, b_data, b_result;
    logic       b_out_valid, b_out_div3, b_out_ready;
    logic [1:0] b_in_data, b_out_word;

    mod3_frame_tx #(.W(2), .GAP(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .start(b_start), .stop(b_stop), .data(b_data),
        .result(b_result), .out_valid(b_out_valid), .out_word(b_out_word),
        .out_div3(b_out_div3), .out_ready(b_out_ready)
    );

    // External divisibility counter model: remainder of the MSB-first bit stream.
    logic [1:0] a_rem, b_rem;
    logic       a_mf, b_mf;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rem <= 2'd0; a_mf <= 1'b0;
        end else if (a_start) begin
            a_rem <= {1'b0, a_data}; a_mf <= 1'b1;
        end else if (a_mf) begin
            a_rem <= 2'((2 * int'(a_rem) + int'(a_data)) % 3);
            if (a_stop) a_mf <= 1'b0;
        end
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rem <= 2'd0; b_mf <= 1'b0;
        end else if (b_start) begin
            b_rem <= {1'b0, b_data}; b_mf <= 1'b1;
        end else if (b_mf) begin
            b_rem <= 2'((2 * int'(b_rem) + int'(b_data)) % 3);
            if (b_stop) b_mf <= 1'b0;
        end
    end
    assign a_result = (a_rem == 2'd0);
    assign b_result = (b_rem == 2'd0);

    // Input drivers: stream a queue through the valid/ready handshake.
    logic [7:0] a_txq[$];
    logic [1:0] b_txq[$];

    initial begin
        a_in_valid = 1'b0; a_in_data = '0;
        forever begin
            logic hs;
            @(negedge clk);
            hs = a_in_valid && a_in_ready;
            @(posedge clk); #1;
            if (hs && a_txq.size() > 0) void'(a_txq.pop_front());
            a_in_valid = (a_txq.size() > 0);
            a_in_data  = (a_txq.size() > 0) ? a_txq[0] : 8'h00;
        end
    end

    initial begin
        b_in_valid = 1'b0; b_in_data = '0;
        forever begin
            logic hs;
            @(negedge clk);
            hs = b_in_valid && b_in_ready;
            @(posedge clk); #1;
            if (hs && b_txq.size() > 0) void'(b_txq.pop_front());
            b_in_valid = (b_txq.size() > 0);
            b_in_data  = (b_txq.size() > 0) ? b_txq[0] : 2'd0;
        end
    end

    // Monitors, sampled mid-cycle.
    rec_t        a_recq[$], b_recq[$];
    logic [31:0] a_serq[$];
    int          a_startq[$];
    logic [31:0] a_acc = '0;
    logic        a_inf = 1'b0;
    int          a_nstart = 0, a_nstop = 0, a_ov_cnt = 0;
    int          b_nstart = 0, b_bad = 0, coinc = 0;
    logic        b_prev_start = 1'b0;

    always @(negedge clk) begin : mon_a
        logic [31:0] nx;
        nx = a_start ? {31'd0, a_data} : {a_acc[30:0], a_data};
        if (!rst_n) begin
            a_inf <= 1'b0;
        end else begin
            if (a_start || a_inf) a_acc <= nx;
            if (a_start) begin
                a_inf    <= 1'b1;
                a_nstart <= a_nstart + 1;
                a_startq.push_back(cyc);
            end
            if (a_stop) begin
                if (a_inf) a_serq.push_back(nx);
                a_inf   <= 1'b0;
                a_nstop <= a_nstop + 1;
            end
            if (a_out_valid && a_out_ready) a_recq.push_back('{{24'd0, a_out_word}, a_out_div3});
            if (a_out_valid) a_ov_cnt <= a_ov_cnt + 1;
        end
    end

    always @(negedge clk) begin : mon_b
        if (rst_n) begin
            if (b_start) b_nstart <= b_nstart + 1;
            if (b_stop != b_prev_start) b_bad <= b_bad + 1;
            if (b_out_valid && b_out_ready) b_recq.push_back('{{30'd0, b_out_word}, b_out_div3});
            if ((a_start && a_stop) || (b_start && b_stop)) coinc <= coinc + 1;
        end
        b_prev_start <= b_start & rst_n;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_a(input int n, input int budget);
        for (int i = 0; i < budget && a_recq.size() < n; i++) @(negedge clk);
        chk("a_record_count", a_recq.size(), n);
    endtask

    vec_t        vt[9];
    rec_t        r;
    logic [7:0]  exp_words[$];
    logic [31:0] held;
    int          base, base2, stable_bad;

    initial begin
        rst_n = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
        vt[0] = '{8'h09, 1'b1}; vt[1] = '{8'h07, 1'b0}; vt[2] = '{8'h0C, 1'b1};
        vt[3] = '{8'hFF, 1'b1}; vt[4] = '{8'h00, 1'b1}; vt[5] = '{8'h01, 1'b0};
        vt[6] = '{8'h80, 1'b0}; vt[7] = '{8'hAA, 1'b0}; vt[8] = '{8'h33, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_word", a_out_word, 0);
        chk("rst_out_div3", a_out_div3, 0);
        chk("rst_ssd", {a_start, a_stop, a_data}, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        rst_n = 1'b1; #1;
        chk("rdy_before_edge", a_in_ready, 0);
        @(posedge clk); #1;
        chk("rdy_first_edge", a_in_ready, 1);

        // Single words, out_ready high: serial stream, record and one-cycle out_valid
        foreach (vt[i]) begin
            base = a_ov_cnt;
            a_txq.push_back(vt[i].word);
            wait_a(1, 60);
            repeat (3) @(negedge clk);
            if (a_recq.size() > 0) begin
                r = a_recq.pop_front();
                chk($sformatf("vec%0d_word", i), r.word, {24'd0, vt[i].word});
                chk($sformatf("vec%0d_div3", i), {31'd0, r.div3}, {31'd0, vt[i].exp_div3});
            end
            chk($sformatf("vec%0d_serial", i), (a_serq.size() > 0) ? a_serq.pop_front() : 32'hDEAD, {24'd0, vt[i].word});
            chk($sformatf("vec%0d_ov_cycles", i), a_ov_cnt - base, 1);
        end

        // Back-to-back frames: start spacing W+2
        a_startq.delete(); a_recq.delete();
        a_txq.push_back(8'h07); a_txq.push_back(8'h0C);
        wait_a(2, 80);
        chk("b2b_start_spacing", (a_startq.size() >= 2) ? a_startq[1] - a_startq[0] : -1, 10);
        if (a_recq.size() >= 2) begin
            chk("b2b_first_div3", {31'd0, a_recq[0].div3}, 0);
            chk("b2b_second_div3", {31'd0, a_recq[1].div3}, 1);
            chk("b2b_order", a_recq[1].word, 32'h0C);
        end

        // Downstream stall: record held, no new frame, buffer blocks input
        repeat (3) @(negedge clk);
        a_recq.delete();
        a_out_ready = 1'b0;
        a_txq.push_back(8'h10); a_txq.push_back(8'h15); a_txq.push_back(8'h1E);
        for (int i = 0; i < 60 && !a_out_valid; i++) @(negedge clk);
        chk("stall_valid_rise", a_out_valid, 1);
        held = {24'd0, a_out_word};
        base = a_nstart; stable_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!a_out_valid || {24'd0, a_out_word} != held) stable_bad++;
        end
        chk("stall_word", held, 32'h10);
        chk("stall_stable", stable_bad, 0);
        chk("stall_no_start", a_nstart - base, 0);
        chk("stall_in_ready", a_in_ready, 0);
        a_out_ready = 1'b1;
        wait_a(3, 100);
        if (a_recq.size() >= 3) begin
            chk("stall_rec0", {a_recq[0].word[30:0], a_recq[0].div3}, {31'h10, 1'b0});
            chk("stall_rec1", {a_recq[1].word[30:0], a_recq[1].div3}, {31'h15, 1'b1});
            chk("stall_rec2", {a_recq[2].word[30:0], a_recq[2].div3}, {31'h1E, 1'b1});
        end

        // Reset on the 4th shift cycle
        repeat (3) @(negedge clk);
        a_recq.delete(); a_serq.delete();
        a_txq.push_back(8'h5A);
        for (int i = 0; i < 40 && !a_start; i++) @(negedge clk);
        chk("rstmid_saw_start", a_start, 1);
        repeat (3) @(negedge clk);
        base = a_nstop;
        #2 rst_n = 1'b0; #1;
        chk("rstmid_outputs", {a_start, a_stop, a_data, a_out_valid, a_in_ready}, 0);
        chk("rstmid_word", {a_out_word, a_out_div3}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1; #1;
        chk("rstmid_rdy_low", a_in_ready, 0);
        @(posedge clk); #1;
        chk("rstmid_rdy_high", a_in_ready, 1);
        chk("rstmid_no_stop", a_nstop - base, 0);
        chk("rstmid_no_record", a_recq.size(), 0);
        a_txq.push_back(8'hFF);
        wait_a(1, 60);
        repeat (2) @(negedge clk);
        chk("rstmid_ff_serial", (a_serq.size() > 0) ? a_serq.pop_front() : 32'hDEAD, 32'hFF);
        if (a_recq.size() > 0) begin
            r = a_recq.pop_front();
            chk("rstmid_ff_rec", {r.word[30:0], r.div3}, {31'hFF, 1'b1});
        end

        // W=2, GAP=0 stream
        base = b_nstart; base2 = b_bad;
        for (int i = 0; i < 4; i++) b_txq.push_back(2'(i));
        for (int i = 0; i < 200 && b_recq.size() < 4; i++) @(negedge clk);
        chk("w2_record_count", b_recq.size(), 4);
        if (b_recq.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("w2_word%0d", i), b_recq[i].word, i);
                chk($sformatf("w2_div3_%0d", i), {31'd0, b_recq[i].div3}, {31'd0, (i % 3) == 0});
            end
        end
        chk("w2_starts", b_nstart - base, 4);
        chk("w2_start_stop_seq", b_bad - base2, 0);

        // Random words with random out_ready
        a_recq.delete(); a_serq.delete();
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] w;
            w = 8'($urandom_range(0, 255));
            exp_words.push_back(w);
            a_txq.push_back(w);
        end
        for (int i = 0; i < 40000 && a_recq.size() < 1000; i++) begin
            @(posedge clk); #1;
            a_out_ready = 1'($urandom_range(0, 1));
        end
        a_out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rand_record_count", a_recq.size(), 1000);
        for (int i = 0; i < 1000 && i < a_recq.size(); i++) begin
            chk($sformatf("rand_rec%0d", i), {a_recq[i].word[30:0], a_recq[i].div3},
                {23'd0, exp_words[i], (exp_words[i] % 3) == 0});
        end

        chk("start_stop_coincident", coinc, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod3_frame_tx.md
MOD3_FRAME_TX -- requirements
Module: mod3_frame_tx

Interface
REQ-001 Parameter W, default 8: serialized word width; legal range 2..32.
REQ-002 Parameter GAP, default 1: idle cycles inserted between frames; legal range 0..7.
REQ-003 clk  in  1  sole clock; all state on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  upstream word available.
REQ-006 in_data  in  W  upstream word.
REQ-007 in_ready  out  1  block accepts in_data this cycle.
REQ-008 start  out  1  first-bit marker to divisibility counter.
REQ-009 stop  out  1  last-bit marker to divisibility counter.
REQ-010 data  out  1  serial bit, MSB first.
REQ-011 result  in  1  counter verdict: 1 = frame value divisible by 3.
REQ-012 out_valid  out  1  verdict record available.
REQ-013 out_word  out  W  word the verdict belongs to.
REQ-014 out_div3  out  1  captured verdict.
REQ-015 out_ready  in  1  downstream accepts record.

Function
REQ-016 The input handshake SHALL complete on a cycle with in_valid=1 and in_ready=1; in_data is captured into a one-entry input buffer.
REQ-017 in_ready SHALL equal "input buffer empty"; the buffer SHALL accept a new word while a previous frame is still shifting.
REQ-018 The FSM SHALL have states IDLE, SHIFT, CATCH, GAPW, HOLD.
REQ-019 IDLE: on buffer full, move the buffer into the shift register and the tag register, free the buffer, and enter SHIFT next cycle.
REQ-020 SHIFT: exactly W cycles; data = shift-register MSB, shifting left by 1 each cycle.
REQ-021 start SHALL be 1 only in the first SHIFT cycle; stop SHALL be 1 only in the W-th SHIFT cycle; start and stop SHALL never be high together.
REQ-022 Outside SHIFT, start, stop and data SHALL be 0.
REQ-023 CATCH: one cycle directly after the stop cycle; result is sampled into out_div3, out_word is loaded from the tag, and out_valid rises next cycle.
REQ-024 After CATCH the FSM SHALL enter GAPW for GAP cycles (skipped when GAP=0), then HOLD if out_valid is still 1, else IDLE.
REQ-025 A new frame SHALL NOT start while out_valid=1 and out_ready=0; the record SHALL stay stable until taken (no overwrite, no loss).
REQ-026 out_valid SHALL fall on the cycle after out_valid=1 and out_ready=1.
REQ-027 With out_ready tied high, GAP=1 and in_valid continuously high, the frame period SHALL be W+2 cycles (W shift, 1 catch, 1 gap).
REQ-028 Bit counter width SHALL be ceil(log2(W)) bits; it counts W-1 down to 0 with no wrap beyond the frame.
REQ-029 in_valid/in_data changes while in_ready=0 SHALL have no effect.

Reset
REQ-030 While rst_n=0: FSM=IDLE, buffers empty, in_ready=0, start=stop=data=0, out_valid=0, out_word=0, out_div3=0.
REQ-031 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-032 Reset mid-frame SHALL abort immediately with no stop pulse; the partial word is discarded.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (3-bit) and the W/GAP range constants.
REQ-034 The piso shift register plus bit counter SHALL be one sub-module, piso_shifter (load, shift, last-bit flag); FSM, buffers and output record stay in the top.

Verification
REQ-035 W=8, word 8'h09, out_ready=1 -> start with data=0, bits 0,0,0,0,1,0,0,1, stop on 8th; model result=1 -> out_word=09, out_div3=1, out_valid 1 cycle.
REQ-036 W=8, back-to-back words 0x07, 0x0C, continuous in_valid -> second start exactly W+2 cycles after first; verdicts 0 then 1, in order.
REQ-037 out_ready=0 for 20 cycles after first record -> record held stable, no second start, in_ready=0 once buffer full; release -> second frame proceeds.
REQ-038 rst_n pulled low on 4th SHIFT cycle -> all outputs 0 asynchronously, no stop pulse; after release, in_ready=1 next edge and fresh word 0xFF serializes correctly.
REQ-039 W=2, GAP=0, words 0,1,2,3 streamed -> start/stop on alternate cycles, never coincident; verdicts 1,0,0,1.
REQ-040 Random 1000 words, random out_ready -> every word yields one record, verdict = (word mod 3 == 0), order preserved.
